// File: rtl/vc_read_scheduler.sv
// Shares one buffer read path among VC_NUM virtual-channel buffers.
// Round-robin between packets, wormhole lock from head to tail.
module vc_read_scheduler #(
  parameter int VC_NUM    = 4,
  parameter int VC_SIZE   = $clog2(VC_NUM),
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [VC_NUM-1:0]    is_empty_i,
  input  logic [VC_NUM-1:0]    head_is_head_i,
  input  logic [VC_NUM-1:0]    head_is_tail_i,
  input  logic [VC_NUM-1:0]    downstream_on_i,
  input  logic                 link_ready_i,
  output logic [VC_NUM-1:0]    read_o,
  output logic [VC_SIZE-1:0]   sel_vc_o,
  output logic                 valid_o,
  output logic                 locked_o,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] pkt_count_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               r_state, w_state_nxt;
  logic [VC_SIZE-1:0]   r_rr_ptr, w_rr_nxt;
  logic [VC_SIZE-1:0]   r_lock_vc, w_lock_nxt;
  logic                 r_err, w_err_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [VC_NUM-1:0]    w_elig, w_cand, w_read;
  logic [VC_SIZE-1:0]   w_win, w_sel;
  logic                 w_found, w_grant, w_tail_out;

  function automatic logic [VC_SIZE-1:0] f_inc(input logic [VC_SIZE-1:0] v);
    return (v == VC_SIZE'(VC_NUM-1)) ? '0 : v + VC_SIZE'(1);
  endfunction

  assign w_elig = ~is_empty_i & downstream_on_i;
  assign w_cand = w_elig & head_is_head_i;

  // Scan from highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin : rr_search
    logic [VC_SIZE:0] idx;
    idx     = '0;
    w_found = 1'b0;
    w_win   = r_rr_ptr;
    for (int i = VC_NUM-1; i >= 0; i--) begin
      idx = {1'b0, r_rr_ptr} + (VC_SIZE+1)'(i);
      if (idx >= (VC_SIZE+1)'(VC_NUM))
        idx = idx - (VC_SIZE+1)'(VC_NUM);
      if (w_cand[idx[VC_SIZE-1:0]]) begin
        w_found = 1'b1;
        w_win   = idx[VC_SIZE-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_lock_nxt  = r_lock_vc;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    w_tail_out  = 1'b0;
    w_sel       = r_rr_ptr;
    unique case (r_state)
      IDLE: begin
        if (|(w_elig & ~head_is_head_i))
          w_err_nxt = 1'b1;
        if (w_found && link_ready_i) begin
          w_grant = 1'b1;
          w_sel   = w_win;
          if (head_is_tail_i[w_win]) begin
            w_tail_out = 1'b1;
            w_rr_nxt   = f_inc(w_win);
          end else begin
            w_state_nxt = LOCKED;
            w_lock_nxt  = w_win;
          end
        end
      end
      LOCKED: begin
        w_sel = r_lock_vc;
        if (w_elig[r_lock_vc] && link_ready_i) begin
          w_grant = 1'b1;
          if (head_is_head_i[r_lock_vc])
            w_err_nxt = 1'b1;
          if (head_is_tail_i[r_lock_vc]) begin
            w_tail_out  = 1'b1;
            w_state_nxt = IDLE;
            w_rr_nxt    = f_inc(r_lock_vc);
          end
        end
      end
      default: ;
    endcase
    if (w_tail_out && (r_cnt != '1))
      w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
    if (!rst)
      w_grant = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_lock_vc <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_lock_vc <= w_lock_nxt;
      r_err     <= w_err_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign w_read      = w_grant ? (VC_NUM'(1) << w_sel) : '0;
  assign read_o      = w_read;
  assign valid_o     = |w_read;
  assign sel_vc_o    = w_sel;
  assign locked_o    = (r_state == LOCKED);
  assign err_o       = r_err;
  assign pkt_count_o = r_cnt;

endmodule

// File: tb/tb_vc_read_scheduler.sv
// Directed bench for vc_read_scheduler with four VCs.
// A narrow packet counter makes saturation reachable.
module tb_vc_read_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] emp, hh, ht, on;
  logic       lr;
  logic [3:0] rd;
  logic [1:0] sel;
  logic       valid, locked, err;
  logic [1:0] pkt;

  int total = 0;
  int bad   = 0;

  vc_read_scheduler #(
    .VC_NUM(4),
    .CNT_WIDTH(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .is_empty_i     (emp),
    .head_is_head_i (hh),
    .head_is_tail_i (ht),
    .downstream_on_i(on),
    .link_ready_i   (lr),
    .read_o         (rd),
    .sel_vc_o       (sel),
    .valid_o        (valid),
    .locked_o       (locked),
    .err_o          (err),
    .pkt_count_o    (pkt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [3:0] e, input logic [3:0] h,
                     input logic [3:0] t, input logic [3:0] o,
                     input logic l);
    emp = e; hh = h; ht = t; on = o; lr = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drv(4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    // reset with every VC offering a HEAD flit
    rst = 1'b0;
    drv(4'b0000, 4'b1111, 4'b0000, 4'b1111, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read", 16'(rd), 16'h0);
    chk("rst_valid", 16'(valid), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_pkt", 16'(pkt), 16'h0);
    chk("rst_locked", 16'(locked), 16'h0);
    rst = 1'b1;
    #1;
    chk("first_read", 16'(rd), 16'h1);
    chk("first_valid", 16'(valid), 16'h1);
    tick();
    drv(4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b1);
    #1;
    chk("first_locked", 16'(locked), 16'h1);
    do_reset();
    #1;
    chk("rst_abandon_lock", 16'(locked), 16'h0);

    // round-robin between two HEADTAIL flits
    drv(4'b0101, 4'b1010, 4'b1010, 4'b1111, 1'b1);
    #1;
    chk("rr_c0", 16'(rd), 16'h2);
    tick();
    drv(4'b0111, 4'b1010, 4'b1010, 4'b1111, 1'b1);
    #1;
    chk("rr_c1", 16'(rd), 16'h8);
    chk("rr_c1_sel", 16'(sel), 16'h3);
    tick();
    drv(4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b1);
    #1;
    chk("rr_c2", 16'(rd), 16'h0);
    chk("rr_c2_valid", 16'(valid), 16'h0);
    chk("rr_wrap_sel", 16'(sel), 16'h0);
    chk("rr_pkt", 16'(pkt), 16'h2);

    // VC0 H,B,T locked while VC2 HEADTAIL waits
    do_reset();
    drv(4'b1010, 4'b0101, 4'b0100, 4'b1111, 1'b1);
    #1;
    chk("lk_c0", 16'(rd), 16'h1);
    tick();
    drv(4'b1010, 4'b0100, 4'b0100, 4'b1111, 1'b1);
    #1;
    chk("lk_c1", 16'(rd), 16'h1);
    chk("lk_c1_locked", 16'(locked), 16'h1);
    chk("lk_c1_sel", 16'(sel), 16'h0);
    tick();
    drv(4'b1010, 4'b0100, 4'b0101, 4'b1111, 1'b1);
    #1;
    chk("lk_c2", 16'(rd), 16'h1);
    chk("lk_c2_locked", 16'(locked), 16'h1);
    tick();
    drv(4'b1011, 4'b0100, 4'b0100, 4'b1111, 1'b1);
    #1;
    chk("lk_c3", 16'(rd), 16'h4);
    chk("lk_c3_locked", 16'(locked), 16'h0);
    tick();
    drv(4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b1);
    #1;
    chk("lk_pkt", 16'(pkt), 16'h2);
    chk("lk_err", 16'(err), 16'h0);

    // downstream off stalls locked VC0 while VC1 is eligible
    do_reset();
    drv(4'b1100, 4'b0011, 4'b0010, 4'b1111, 1'b1);
    #1;
    chk("fc_head", 16'(rd), 16'h1);
    tick();
    drv(4'b1100, 4'b0010, 4'b0010, 4'b1110, 1'b1);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("fc_stall", 16'(rd), 16'h0);
      chk("fc_stall_locked", 16'(locked), 16'h1);
      tick();
    end
    drv(4'b1100, 4'b0010, 4'b0011, 4'b1111, 1'b1);
    #1;
    chk("fc_resume", 16'(rd), 16'h1);
    tick();
    drv(4'b1101, 4'b0010, 4'b0010, 4'b1111, 1'b1);
    #1;
    chk("fc_next", 16'(rd), 16'h2);
    chk("fc_err", 16'(err), 16'h0);

    // link backpressure leaves rr_ptr untouched
    do_reset();
    drv(4'b1011, 4'b0100, 4'b0100, 4'b1111, 1'b0);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("lr_block", 16'(rd), 16'h0);
      chk("lr_sel", 16'(sel), 16'h0);
      tick();
    end
    lr = 1'b1;
    #1;
    chk("lr_grant", 16'(rd), 16'h4);
    chk("lr_grant_sel", 16'(sel), 16'h2);
    tick();
    drv(4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b1);
    #1;
    chk("lr_rr_ptr", 16'(sel), 16'h3);

    // BODY flit at head of VC1 while IDLE
    do_reset();
    drv(4'b1101, 4'b0000, 4'b0000, 4'b1111, 1'b1);
    #1;
    chk("pe_no_read", 16'(rd), 16'h0);
    chk("pe_err_pre", 16'(err), 16'h0);
    tick();
    drv(4'b1100, 4'b0001, 4'b0001, 4'b1111, 1'b1);
    #1;
    chk("pe_err_set", 16'(err), 16'h1);
    chk("pe_vc0_only", 16'(rd), 16'h1);
    tick();
    drv(4'b1101, 4'b0000, 4'b0000, 4'b1111, 1'b1);
    #1;
    chk("pe_err_sticky", 16'(err), 16'h1);
    chk("pe_vc1_never", 16'(rd), 16'h0);
    do_reset();
    #1;
    chk("pe_err_clear", 16'(err), 16'h0);

    // counter saturates at 3 instead of wrapping
    drv(4'b0000, 4'b1111, 4'b1111, 4'b1111, 1'b1);
    repeat (3) tick();
    chk("sat_pkt3", 16'(pkt), 16'h3);
    chk("sat_rr", 16'(rd), 16'h8);
    repeat (2) tick();
    chk("sat_hold", 16'(pkt), 16'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
